// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - pointer-then-data byte register bank behind an I2C slave
module i2c_reg_bank #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [7:0]  RD_UNIMPL = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_in,
  input  logic                  sda_in,
  input  logic                  read_req,
  output logic [7:0]            data_to_master,
  input  logic                  data_valid,
  input  logic [7:0]            data_from_master,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic [7:0]            ptr
);

  localparam int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  NUM_REGS_W = 9'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_PTR = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;
  logic start_det, stop_det;

  logic [7:0] mem [NUM_REGS];
  logic       in_range;
  logic [AW-1:0] idx;

  logic do_load_ptr;
  logic do_write;
  logic do_inc;

  // Two-flop synchronizers plus a previous-sample stage; idle bus is high
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl_in;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda_in;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  assign start_det = scl_s2 && scl_prev && sda_prev && !sda_s2;
  assign stop_det  = scl_s2 && scl_prev && !sda_prev && sda_s2;

  assign in_range = {1'b0, ptr} < NUM_REGS_W;
  assign idx      = ptr[AW-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: STOP beats START, START beats any byte in the same cycle
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = ST_IDLE;
    end else if (start_det) begin
      state_nxt = ST_GET_PTR;
    end else if (state == ST_GET_PTR && data_valid) begin
      state_nxt = ST_DATA;
    end
  end

  // FSM outputs: decode which datapath action this cycle performs
  always_comb begin
    do_load_ptr = 1'b0;
    do_write    = 1'b0;
    do_inc      = 1'b0;
    if (!start_det && !stop_det && state != ST_IDLE) begin
      if (data_valid) begin
        if (state == ST_GET_PTR) begin
          do_load_ptr = 1'b1;
        end else begin
          do_write = in_range;
          do_inc   = 1'b1;
        end
      end else if (read_req) begin
        do_inc = 1'b1;
      end
    end
  end

  // Register pointer; kept across START/STOP so reads can resume
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 8'h00;
    end else if (do_load_ptr) begin
      ptr <= data_from_master;
    end else if (do_inc) begin
      ptr <= ptr + 8'h01;
    end
  end

  // Register storage; writes to unimplemented addresses never reach here
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (do_write) begin
      mem[idx] <= data_from_master;
    end
  end

  // Write notification, one cycle after the accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= 8'h00;
    end else begin
      wr_strobe <= do_write;
      if (do_write) begin
        wr_addr <= ptr;
      end
    end
  end

  // Read byte reloaded every cycle so it tracks the pointer one clk later
  always_ff @(posedge clk) begin
    if (rst) begin
      data_to_master <= 8'h00;
    end else begin
      data_to_master <= in_range ? mem[idx] : RD_UNIMPL;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[8*g +: 8] = mem[g];
  end

endmodule
